// File: rtl/execute_stage2.sv
// execute_stage2: stage-2 controller of the pipelined BPF CPU.
// Registers ALU/operand controls and A/X writeback selects for stage 3,
// sequences multi-cycle packet-memory loads and stalls stage 1 while one
// is outstanding.
// Optional feature macro: MEM_TIMEOUT_EN (abort a load after TIMEOUT_CYCLES
// WAIT cycles without rd_ready, pulsing mem_err).
//
// state  | meaning
// -------+-----------------------------------------------
// S_RUN  | ready to accept an instruction from stage 1
// S_WAIT | packet load outstanding, stage 1 stalled
module execute_stage2 #(
  parameter int SEL_W          = 3,
  parameter int ALU_W          = 4,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid_in,
  input  logic [SEL_W-1:0] A_sel_in,
  input  logic             A_en_in,
  input  logic [SEL_W-1:0] X_sel_in,
  input  logic             X_en_in,
  input  logic [ALU_W-1:0] ALU_sel_in,
  input  logic             B_sel_in,
  input  logic             is_load_in,
  input  logic [1:0]       ld_width_in,
  input  logic             rd_ready,
  output logic             stall,
  output logic             rd_en,
  output logic [1:0]       rd_width,
  output logic [ALU_W-1:0] ALU_sel,
  output logic             B_sel,
  output logic [SEL_W-1:0] A_sel,
  output logic             A_en,
  output logic [SEL_W-1:0] X_sel,
  output logic             X_en,
  output logic             mem_err
);

  typedef enum logic {S_RUN = 1'b0, S_WAIT = 1'b1} state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic             w_accept;
  logic             w_done;
  logic             w_abort;
  logic [1:0]       w_ld_width;

  logic [ALU_W-1:0] r_alu_sel;
  logic             r_b_sel;
  logic [SEL_W-1:0] r_a_sel;
  logic             r_a_en;
  logic [SEL_W-1:0] r_x_sel;
  logic             r_x_en;
  logic             r_rd_en;
  logic [1:0]       r_rd_width;
  logic             r_mem_err;

  // fields of the outstanding load, applied when the read completes
  logic [ALU_W-1:0] r_l_alu_sel;
  logic             r_l_b_sel;
  logic [SEL_W-1:0] r_l_a_sel;
  logic             r_l_a_en;
  logic [SEL_W-1:0] r_l_x_sel;
  logic             r_l_x_en;
  logic [15:0]      r_cnt;

  // accept/complete/abort qualifiers derived from the state register
  always_comb begin
    w_accept   = valid_in && (r_state == S_RUN);
    w_done     = (r_state == S_WAIT) && rd_ready;
    // reserved width code 3 is issued to memory as a word access
    w_ld_width = (ld_width_in == 2'd3) ? 2'd2 : ld_width_in;
`ifdef MEM_TIMEOUT_EN
    w_abort    = (r_state == S_WAIT) && !rd_ready &&
                 (r_cnt == 16'(TIMEOUT_CYCLES - 1));
`else
    w_abort    = 1'b0;
`endif
  end

  // next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_RUN:   if (w_accept && is_load_in) w_state_nxt = S_WAIT;
      S_WAIT:  if (w_done || w_abort)      w_state_nxt = S_RUN;
      default: w_state_nxt = S_RUN;
    endcase
  end

  // state register
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_RUN;
    else     r_state <= w_state_nxt;
  end

  // output, latch and wait-counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_alu_sel   <= '0;
      r_b_sel     <= 1'b0;
      r_a_sel     <= '0;
      r_a_en      <= 1'b0;
      r_x_sel     <= '0;
      r_x_en      <= 1'b0;
      r_rd_en     <= 1'b0;
      r_rd_width  <= 2'd0;
      r_mem_err   <= 1'b0;
      r_l_alu_sel <= '0;
      r_l_b_sel   <= 1'b0;
      r_l_a_sel   <= '0;
      r_l_a_en    <= 1'b0;
      r_l_x_sel   <= '0;
      r_l_x_en    <= 1'b0;
      r_cnt       <= 16'd0;
    end else begin
      r_mem_err <= 1'b0;
      if (r_state == S_RUN) begin
        r_a_en <= 1'b0;
        r_x_en <= 1'b0;
        if (w_accept && !is_load_in) begin
          r_alu_sel <= ALU_sel_in;
          r_b_sel   <= B_sel_in;
          r_a_sel   <= A_sel_in;
          r_a_en    <= A_en_in;
          r_x_sel   <= X_sel_in;
          r_x_en    <= X_en_in;
        end else if (w_accept) begin
          r_rd_en     <= 1'b1;
          r_rd_width  <= w_ld_width;
          r_l_alu_sel <= ALU_sel_in;
          r_l_b_sel   <= B_sel_in;
          r_l_a_sel   <= A_sel_in;
          r_l_a_en    <= A_en_in;
          r_l_x_sel   <= X_sel_in;
          r_l_x_en    <= X_en_in;
          r_cnt       <= 16'd0;
        end
      end else begin
        if (w_done) begin
          r_rd_en   <= 1'b0;
          r_alu_sel <= r_l_alu_sel;
          r_b_sel   <= r_l_b_sel;
          r_a_sel   <= r_l_a_sel;
          r_a_en    <= r_l_a_en;
          r_x_sel   <= r_l_x_sel;
          r_x_en    <= r_l_x_en;
        end else if (w_abort) begin
          r_rd_en   <= 1'b0;
          r_mem_err <= 1'b1;
        end else begin
          r_cnt <= r_cnt + 16'd1;
        end
      end
    end
  end

  assign stall    = (r_state == S_WAIT);
  assign rd_en    = r_rd_en;
  assign rd_width = r_rd_width;
  assign ALU_sel  = r_alu_sel;
  assign B_sel    = r_b_sel;
  assign A_sel    = r_a_sel;
  assign A_en     = r_a_en;
  assign X_sel    = r_x_sel;
  assign X_en     = r_x_en;

`ifdef MEM_TIMEOUT_EN
  assign mem_err  = r_mem_err;
`else
  // without the timeout the pulse register never sets; the port reads 0
  logic [15:0] w_unused_tc;
  logic        w_unused_err;
  assign w_unused_tc  = 16'(TIMEOUT_CYCLES);
  assign w_unused_err = r_mem_err;
  assign mem_err      = 1'b0;
`endif

endmodule

// File: tb/tb_execute_stage2.sv
// Bench for execute_stage2: directed scenarios with literal expectations,
// then random traffic, all outputs compared each cycle to a reference model.
module tb_execute_stage2;
  localparam int SEL_W = 3;
  localparam int ALU_W = 4;
  localparam int TO    = 8;

  logic clk = 1'b0;
  logic rst, valid_in, A_en_in, X_en_in, B_sel_in, is_load_in, rd_ready;
  logic [SEL_W-1:0] A_sel_in, X_sel_in;
  logic [ALU_W-1:0] ALU_sel_in;
  logic [1:0] ld_width_in;
  logic stall, rd_en, B_sel, A_en, X_en, mem_err;
  logic [1:0] rd_width;
  logic [ALU_W-1:0] ALU_sel;
  logic [SEL_W-1:0] A_sel, X_sel;

  int errors = 0;
  int checks = 0;
  bit cmp_on = 0;

  execute_stage2 #(.SEL_W(SEL_W), .ALU_W(ALU_W), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .valid_in(valid_in), .A_sel_in(A_sel_in),
    .A_en_in(A_en_in), .X_sel_in(X_sel_in), .X_en_in(X_en_in),
    .ALU_sel_in(ALU_sel_in), .B_sel_in(B_sel_in), .is_load_in(is_load_in),
    .ld_width_in(ld_width_in), .rd_ready(rd_ready), .stall(stall),
    .rd_en(rd_en), .rd_width(rd_width), .ALU_sel(ALU_sel), .B_sel(B_sel),
    .A_sel(A_sel), .A_en(A_en), .X_sel(X_sel), .X_en(X_en), .mem_err(mem_err));

  always #5 clk = ~clk;

  // reference model: the stage-3 view plus one pending load
  typedef struct packed {
    logic [ALU_W-1:0] alu;
    logic             b;
    logic [SEL_W-1:0] as;
    logic             ae;
    logic [SEL_W-1:0] xs;
    logic             xe;
  } ctl_t;

  ctl_t m_out = '0;
  ctl_t m_pend = '0;
  bit   m_busy = 0;
  logic m_rd_en = 0;
  logic [1:0] m_width = 0;
  logic m_err = 0;
  int   m_waited = 0;

  always @(posedge clk) begin
    ctl_t in;
    in = '{ALU_sel_in, B_sel_in, A_sel_in, A_en_in, X_sel_in, X_en_in};
    m_err = 0;
    if (rst) begin
      m_out = '0; m_pend = '0; m_busy = 0; m_rd_en = 0; m_width = 0;
    end else if (!m_busy) begin
      if (valid_in && !is_load_in) m_out = in;
      else begin
        m_out.ae = 0; m_out.xe = 0;
        if (valid_in) begin
          m_pend = in; m_busy = 1; m_rd_en = 1; m_waited = 0;
          m_width = (ld_width_in == 2'd3) ? 2'd2 : ld_width_in;
        end
      end
    end else if (rd_ready) begin
      m_out = m_pend; m_busy = 0; m_rd_en = 0;
    end else begin
      m_waited++;
`ifdef MEM_TIMEOUT_EN
      if (m_waited == TO) begin
        m_busy = 0; m_rd_en = 0; m_err = 1;
      end
`endif
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // model compare, every cycle, away from the active edge
  always @(negedge clk) begin
    if (cmp_on) begin
      chk("m_stall", int'(stall), int'(m_busy));
      chk("m_rd_en", int'(rd_en), int'(m_rd_en));
      chk("m_rd_width", int'(rd_width), int'(m_width));
      chk("m_ALU_sel", int'(ALU_sel), int'(m_out.alu));
      chk("m_B_sel", int'(B_sel), int'(m_out.b));
      chk("m_A_sel", int'(A_sel), int'(m_out.as));
      chk("m_A_en", int'(A_en), int'(m_out.ae));
      chk("m_X_sel", int'(X_sel), int'(m_out.xs));
      chk("m_X_en", int'(X_en), int'(m_out.xe));
      chk("m_mem_err", int'(mem_err), int'(m_err));
    end
  end

  task automatic tick();
    @(posedge clk); #2;
  endtask

  task automatic drive(input logic v, input logic ld, input logic [1:0] w,
                       input logic ae, input logic [2:0] as, input logic xe,
                       input logic [2:0] xs, input logic [3:0] alu, input logic b);
    valid_in = v; is_load_in = ld; ld_width_in = w; A_en_in = ae; A_sel_in = as;
    X_en_in = xe; X_sel_in = xs; ALU_sel_in = alu; B_sel_in = b;
  endtask

  initial begin
    rst = 1; rd_ready = 1;
    drive(1, 0, 0, 1, 3'd7, 1, 3'd7, 4'd9, 1);
    tick(); cmp_on = 1;
    tick(); tick();
    chk("rst_A_en", A_en, 0); chk("rst_A_sel", A_sel, 0); chk("rst_ALU", ALU_sel, 0);
    chk("rst_stall", stall, 0); chk("rst_rd_en", rd_en, 0); chk("rst_X_en", X_en, 0);

    // back-to-back non-loads
    rst = 0; rd_ready = 0;
    drive(1, 0, 0, 1, 3'd2, 0, 3'd0, 4'd0, 0); tick();
    chk("b2b1_A_en", A_en, 1); chk("b2b1_A_sel", A_sel, 2); chk("b2b1_stall", stall, 0);
    drive(1, 0, 0, 0, 3'd0, 1, 3'd5, 4'd0, 0); tick();
    chk("b2b2_X_en", X_en, 1); chk("b2b2_X_sel", X_sel, 5); chk("b2b2_A_en", A_en, 0);
    drive(1, 0, 0, 1, 3'd0, 0, 3'd0, 4'd4, 0); tick();
    chk("b2b3_ALU", ALU_sel, 4); chk("b2b3_A_en", A_en, 1);
    drive(0, 0, 0, 1, 3'd1, 1, 3'd1, 4'd1, 0); tick();
    chk("bubble_A_en", A_en, 0); chk("bubble_X_en", X_en, 0); chk("bubble_ALU_hold", ALU_sel, 4);

    // load with latency 4, new ALU instruction held during WAIT
    drive(1, 1, 2'd1, 1, 3'd3, 0, 3'd0, 4'd2, 1); tick();
    drive(1, 0, 0, 1, 3'd6, 0, 3'd0, 4'd7, 0);
    for (int i = 0; i < 4; i++) begin
      chk("ld_rd_en", rd_en, 1); chk("ld_width", rd_width, 1);
      chk("ld_stall", stall, 1); chk("ld_A_en", A_en, 0);
      if (i < 3) tick();
    end
    rd_ready = 1; tick(); rd_ready = 0;
    chk("ldc_A_en", A_en, 1); chk("ldc_A_sel", A_sel, 3); chk("ldc_ALU", ALU_sel, 2);
    chk("ldc_rd_en", rd_en, 0); chk("ldc_stall", stall, 0);
    tick();
    chk("held_A_sel", A_sel, 6); chk("held_ALU", ALU_sel, 7);
    valid_in = 0; tick();

    // reset mid-load
    drive(1, 1, 2'd3, 1, 3'd4, 1, 3'd4, 4'd3, 0); tick();
    valid_in = 0; chk("w3_width", rd_width, 2);
    tick(); rst = 1; tick(); rst = 0;
    chk("rml_rd_en", rd_en, 0); chk("rml_stall", stall, 0); chk("rml_A_en", A_en, 0);
    rd_ready = 1; tick(); rd_ready = 0;
    chk("rml_late_A_en", A_en, 0); chk("rml_late_rd_en", rd_en, 0);

`ifdef MEM_TIMEOUT_EN
    drive(1, 1, 2'd0, 1, 3'd1, 0, 3'd0, 4'd0, 0); tick(); valid_in = 0;
    for (int i = 1; i < TO; i++) tick();
    chk("to_pre_stall", stall, 1);
    tick();
    chk("to_rd_en", rd_en, 0); chk("to_err", mem_err, 1);
    chk("to_A_en", A_en, 0); chk("to_stall", stall, 0);
    tick(); chk("to_err_pulse", mem_err, 0);
    drive(1, 1, 2'd0, 1, 3'd1, 0, 3'd0, 4'd0, 0); tick(); valid_in = 0;
    for (int i = 1; i < TO; i++) tick();
    rd_ready = 1; tick(); rd_ready = 0;
    chk("tor_err", mem_err, 0); chk("tor_A_en", A_en, 1); chk("tor_stall", stall, 0);
`endif

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      drive(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) == 0),
            2'($urandom), 1'($urandom), 3'($urandom), 1'($urandom),
            3'($urandom), 4'($urandom), 1'($urandom));
      rd_ready = 1'($urandom_range(0, 4) == 0);
      rst = 1'($urandom_range(0, 199) == 0);
      tick();
    end
    rst = 0;
    @(negedge clk); cmp_on = 0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/execute_stage2.md
Name: execute_stage2

Overview:
- Stage-2 controller of the pipelined BPF CPU. Sits between the stage-1 fetch/decode controller and the stage-3 writeback controller.
- Accepts pre-decoded control fields from stage 1 and drives ALU/operand-select controls.
- Sequences multi-cycle packet-memory loads.
- Registers the A/X writeback selects and enables that feed stage 3. Stalls stage 1 while a packet load is outstanding.

Parameters:
- SEL_W, 3: width of A_sel/X_sel fields.
- ALU_W, 4: width of ALU_sel field.
- TIMEOUT_CYCLES, 255: cycles spent in WAIT before abort. Used only with MEM_TIMEOUT_EN; range 1..65535.

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous reset, active-high
- valid_in  in  1  stage 1 presents an instruction this cycle
- A_sel_in  in  SEL_W  A writeback source select
- A_en_in  in  1  instruction writes A
- X_sel_in  in  SEL_W  X writeback source select
- X_en_in  in  1  instruction writes X
- ALU_sel_in  in  ALU_W  ALU operation
- B_sel_in  in  1  ALU B operand: 0=X, 1=immediate
- is_load_in  in  1  instruction is a packet-memory load
- ld_width_in  in  2  load width: 0=byte, 1=half, 2=word, 3=reserved (treated as word)
- rd_ready  in  1  packet memory: read data valid this cycle
- stall  out  1  to stage 1: do not advance
- rd_en  out  1  packet memory read request
- rd_width  out  2  latched load width
- ALU_sel  out  ALU_W  registered ALU operation
- B_sel  out  1  registered B operand select
- A_sel, A_en, X_sel, X_en  out  SEL_W/1/SEL_W/1  registered controls to stage 3
- mem_err  out  1  one-cycle pulse on load abort (MEM_TIMEOUT_EN only)

Behaviour:
- Reset values:
  - All outputs 0.
  - State = RUN; timeout counter and latched fields cleared.
  - A reset mid-load drops rd_en in the next cycle, and the pending writeback is discarded.
- States:
  - RUN: ready to accept.
  - WAIT: load outstanding.
- stall = (state == WAIT). Combinational from the state register; no dependence on valid_in.
- Accept = valid_in && !stall.
- RUN, accept of a non-load:
  - On that edge, ALU_sel, B_sel, A_sel, A_en, X_sel, X_en <= inputs; rd_en stays 0.
  - Latency from accept to stage-3 inputs: 1 edge.
- RUN, no accept:
  - A_en, X_en <= 0 (bubble). Sel fields hold their previous values.
- RUN, accept of a load:
  - rd_en <= 1, rd_width <= ld_width_in.
  - A_en, X_en <= 0.
  - Latch A_sel/A_en/X_sel/X_en/ALU_sel/B_sel internally.
  - state <= WAIT.
- WAIT:
  - rd_en held 1 and A_en/X_en held 0 until rd_ready is sampled 1.
  - On that edge: outputs <= latched fields, rd_en <= 0, state <= RUN.
  - stall deasserts the following cycle, so the earliest next accept is on the edge after ready.
- rd_ready sampled in RUN is ignored.
- valid_in while in WAIT is not accepted. Stage 1 must hold its instruction.
- Minimum load latency: accept edge to writeback enable = 2 edges (ready on the first WAIT cycle).
- A load with A_en_in = X_en_in = 0 still performs the read handshake.
- Back-to-back non-loads are accepted every cycle with no bubbles.

Optional Feature:
- Macro: MEM_TIMEOUT_EN.
- With the macro defined:
  - A 16-bit counter clears on entry to WAIT and increments each WAIT cycle without rd_ready.
  - When the count reaches TIMEOUT_CYCLES: rd_en <= 0, state <= RUN, A_en/X_en stay 0, mem_err = 1 for exactly one cycle.
  - rd_ready on the same edge as the timeout wins: the load completes normally with no error.
- Without the macro:
  - WAIT persists indefinitely.
  - mem_err is tied to 0; the port is still present.

Test Plan:
- Reset: hold rst 3 cycles with valid_in=1 and rd_ready=1 → all outputs 0, stall=0; the first accept happens only after rst falls.
- Back-to-back ALU: 3 consecutive non-load instructions (A_en=1, A_sel=2 / X_en=1, X_sel=5 / A_en=1, ALU_sel=4) → each appears on the outputs one edge after its accept, no stall. Fourth cycle with valid_in=0 → A_en=X_en=0.
- Load with latency 4: accept load (ld_width=1, A_en=1, A_sel=3) → rd_en=1, rd_width=1, stall=1 for 4 cycles, A_en=0 throughout. rd_ready pulse → next cycle A_en=1, A_sel=3, rd_en=0, stall=0.
- Stall obedience: valid_in held 1 with a new ALU instruction during WAIT → not accepted until the cycle after rd_ready; then output one edge later.
- Reset mid-load: rst asserted on the 2nd WAIT cycle → next cycle rd_en=0, stall=0, A_en=0. A later rd_ready has no effect.
- Timeout (MEM_TIMEOUT_EN defined, TIMEOUT_CYCLES=8): load with no rd_ready → after 8 WAIT cycles rd_en=0, mem_err high for 1 cycle, A_en stays 0, stall=0. Repeat with rd_ready on the 8th cycle → normal completion, mem_err=0.
